// File: rtl/mod_mult_pkg.sv
// -----------------------------------------------------------------------------
// mod_mult_pkg
// Shared definitions for the digit-serial modular multiplier:
//   - state_e     : controller states (IDLE -> TABLE -> RUN -> DONE)
//   - DEF_*       : default modulus / width / digit size
//   - num_digits  : number of DIGIT-bit digits needed to cover a W-bit operand
// -----------------------------------------------------------------------------
package mod_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TABLE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_MODULUS = 997;
    localparam int DEF_W       = 10;
    localparam int DEF_DIGIT   = 3;

    // ceil(w / digit)
    function automatic int num_digits(input int w, input int digit);
        return (w + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/mod_add.sv
// -----------------------------------------------------------------------------
// mod_add
// Combinational modular adder: s_o = (x_i + y_i) mod MODULUS.
// Both inputs must already be < MODULUS, so the W+1-bit sum is < 2*MODULUS
// and one conditional subtract fully reduces it.
// Ports:
//   x_i [W-1:0] : addend, < MODULUS
//   y_i [W-1:0] : addend, < MODULUS
//   s_o [W-1:0] : reduced sum
// -----------------------------------------------------------------------------
module mod_add
    import mod_mult_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] s_o
);

    localparam logic [W:0] MOD_X = (W+1)'(MODULUS);

    logic [W:0] sum;

    assign sum = {1'b0, x_i} + {1'b0, y_i};
    // After the subtract the top bit is always 0, so truncation is lossless.
    assign s_o = W'((sum >= MOD_X) ? (sum - MOD_X) : sum);

endmodule

// File: rtl/mod_mult_serial.sv
// -----------------------------------------------------------------------------
// mod_mult_serial
// Digit-serial modular multiplier: result = (a * b) mod MODULUS.
// A table t[i] = i*a mod M (i < 2^DIGIT) is built after accept, then b is
// consumed DIGIT bits per cycle MSB-first:
//     acc <- 2^DIGIT * acc (+) t[digit]    (all mod M)
// Optional feature macro: MOD_MULT_RANGE_CHECK_EN
//   defined   : operands >= MODULUS finish in one edge with result 0, err 1
//   undefined : err tied to 0, no range comparison built
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE, out of reset)
//   a, b [W-1:0]        : operands, expected < MODULUS
//   out_valid/out_ready : result handshake (valid held in DONE until taken)
//   result [W-1:0]      : product mod MODULUS
//   err                 : operand range error
// -----------------------------------------------------------------------------
module mod_mult_serial
    import mod_mult_pkg::*;
#(
    parameter int MODULUS = DEF_MODULUS,
    parameter int W       = DEF_W,
    parameter int DIGIT   = DEF_DIGIT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         err
);

    localparam int N   = num_digits(W, DIGIT);
    localparam int NB  = N * DIGIT;
    localparam int TBL = 1 << DIGIT;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;

    localparam logic [DIGIT-1:0] TBL_FIRST = DIGIT'(2);
    localparam logic [DIGIT-1:0] TBL_LAST  = '1;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(N - 1);

    state_e                  state_q, state_d;
    logic [W-1:0]            a_q, a_d;
    logic [NB-1:0]           b_q, b_d;
    logic [W-1:0]            acc_q, acc_d;
    logic [TBL-1:0][W-1:0]   t_q, t_d;
    logic [DIGIT-1:0]        tbl_idx_q, tbl_idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic                    accept;
    logic                    range_bad;
    logic [DIGIT-1:0]        digit;
    logic [DIGIT-1:0]        prev_idx;
    logic [W-1:0]            tbl_sum;
    logic [W-1:0]            acc_sum;
    logic [DIGIT:0][W-1:0]   dbl;

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = acc_q;

`ifdef MOD_MULT_RANGE_CHECK_EN
    localparam logic [W-1:0] MOD_W = W'(MODULUS);
    logic err_q;

    assign range_bad = (a >= MOD_W) || (b >= MOD_W);

    // err reflects the most recent accept and is re-evaluated on each one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= range_bad;
        end
    end
    assign err = err_q;
`else
    assign range_bad = 1'b0;
    assign err       = 1'b0;
`endif

    // ---------------- datapath ----------------
    assign digit    = b_q[NB-1 -: DIGIT];
    assign prev_idx = tbl_idx_q - DIGIT'(1);

    // Table build: t[i] = t[i-1] (+) a
    mod_add #(.W(W), .MODULUS(MODULUS)) u_tbl (
        .x_i (t_q[prev_idx]),
        .y_i (a_q),
        .s_o (tbl_sum)
    );

    // DIGIT chained doublings of acc, each one an x (+) x step.
    assign dbl[0] = acc_q;
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_dbl
        mod_add #(.W(W), .MODULUS(MODULUS)) u_dbl (
            .x_i (dbl[gi]),
            .y_i (dbl[gi]),
            .s_o (dbl[gi+1])
        );
    end

    mod_add #(.W(W), .MODULUS(MODULUS)) u_acc (
        .x_i (dbl[DIGIT]),
        .y_i (t_q[digit]),
        .s_o (acc_sum)
    );

    // ---------------- controller ----------------
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        t_d       = t_q;
        tbl_idx_d = tbl_idx_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d       = a;
                    b_d       = NB'(b);     // zero-extend to whole digits
                    acc_d     = '0;
                    t_d[0]    = '0;
                    t_d[1]    = a;
                    tbl_idx_d = TBL_FIRST;
                    cnt_d     = '0;
                    if (range_bad) begin
                        state_d = ST_DONE;
                    end else if (DIGIT == 1) begin
                        state_d = ST_RUN;   // t[0], t[1] already complete
                    end else begin
                        state_d = ST_TABLE;
                    end
                end
            end
            ST_TABLE: begin
                t_d[tbl_idx_q] = tbl_sum;
                tbl_idx_d      = tbl_idx_q + DIGIT'(1);
                if (tbl_idx_q == TBL_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            t_q       <= '0;
            tbl_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            t_q       <= t_d;
            tbl_idx_q <= tbl_idx_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mod_mult_serial.sv
// -----------------------------------------------------------------------------
// tb_mod_mult_serial
// Directed bench for mod_mult_serial. Two instances run in lock-step on the
// same operands: dut0 with DIGIT=3 and dut1 with DIGIT=1. Both have a
// latency of 10 edges for MODULUS=997, W=10.
// -----------------------------------------------------------------------------
module tb_mod_mult_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [9:0] a = '0;
    logic [9:0] b = '0;

    logic       in_ready0, out_valid0, err0;
    logic [9:0] result0;
    logic       in_ready1, out_valid1, err1;
    logic [9:0] result1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_mult_serial #(.MODULUS(997), .W(10), .DIGIT(3)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .a         (a),
        .b         (b),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .result    (result0),
        .err       (err0)
    );

    mod_mult_serial #(.MODULUS(997), .W(10), .DIGIT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .result    (result1),
        .err       (err1)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Wait for both instances idle, present operands, return just after the accept edge.
    task automatic start_op(input int av, input int bv, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(in_ready0 && in_ready1) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_rdy"}, int'(in_ready0 && in_ready1), 1);
        a        = 10'(av);
        b        = 10'(bv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges to out_valid on both instances, then check the outputs.
    task automatic wait_done(input int exp, input int exp_err, input string tag);
        int lat0, lat1;
        lat0 = -1;
        lat1 = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (out_valid0 && lat0 < 0) lat0 = c;
            if (out_valid1 && lat1 < 0) lat1 = c;
            if (lat0 >= 0 && lat1 >= 0) break;
        end
        check_eq({tag, "_lat0"}, lat0, 10);
        check_eq({tag, "_lat1"}, lat1, 10);
        check_eq({tag, "_res0"}, int'(result0), exp);
        check_eq({tag, "_res1"}, int'(result1), exp);
        check_eq({tag, "_err0"}, int'(err0), exp_err);
        check_eq({tag, "_err1"}, int'(err1), exp_err);
        $display("op %s a=%0d b=%0d res0=%0d res1=%0d lat0=%0d lat1=%0d exp=%0d",
                 tag, a, b, result0, result1, lat0, lat1, exp);
    endtask

    // Take the result for one cycle; both must drop valid and be idle next.
    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_ov0_off"}, int'(out_valid0), 0);
        check_eq({tag, "_ov1_off"}, int'(out_valid1), 0);
        check_eq({tag, "_idle0"}, int'(in_ready0), 1);
        check_eq({tag, "_idle1"}, int'(in_ready1), 1);
    endtask

    task automatic full_op(input int av, input int bv, input int exp, input string tag);
        start_op(av, bv, tag);
        wait_done(exp, 0, tag);
        take(tag);
    endtask

    initial begin
        int seen;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ov0", int'(out_valid0), 0);
        check_eq("rst_res0", int'(result0), 0);
        check_eq("rst_err0", int'(err0), 0);
        check_eq("rst_rdy0", int'(in_ready0), 0);
        check_eq("rst_rdy1", int'(in_ready1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_rdy0", int'(in_ready0), 1);
        check_eq("post_rst_rdy1", int'(in_ready1), 1);

        // ---- main function ----
        full_op(108, 5, 540, "108x5");
        full_op(996, 996, 1, "996x996");
        full_op(500, 2, 3, "500x2");
        full_op(123, 456, 256, "123x456");
        full_op(0, 777, 0, "0x777");
        full_op(777, 0, 0, "777x0");
        full_op(996, 2, 995, "996x2");
        full_op(1, 996, 996, "1x996");

        // ---- back-pressure: hold out_ready low, pulse in_valid ----
        start_op(123, 456, "hold");
        wait_done(256, 0, "hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a        = 10'd7;
            b        = 10'd9;
            in_valid = (i % 2) == 0;
            @(posedge clk);
            #1;
            check_eq($sformatf("hold%0d_ov0", i), int'(out_valid0), 1);
            check_eq($sformatf("hold%0d_res0", i), int'(result0), 256);
            check_eq($sformatf("hold%0d_ov1", i), int'(out_valid1), 1);
            check_eq($sformatf("hold%0d_res1", i), int'(result1), 256);
            check_eq($sformatf("hold%0d_rdy0", i), int'(in_ready0), 0);
        end
        in_valid = 1'b0;
        take("hold");
        // No operation may have been latched by the pulses: stays idle.
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_still_idle0", int'(in_ready0), 1);
        check_eq("hold_still_idle1", int'(in_ready1), 1);

        // ---- reset during RUN aborts with no output ----
        start_op(108, 5, "abort");
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_ov0", int'(out_valid0), 0);
        check_eq("abort_res0", int'(result0), 0);
        check_eq("abort_ov1", int'(out_valid1), 0);
        check_eq("abort_res1", int'(result1), 0);
        check_eq("abort_rdy_gated", int'(in_ready0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid0 || out_valid1) seen = 1;
        end
        check_eq("abort_no_output", seen, 0);
        $display("op abort: reset mid-RUN, outputs cleared");
        full_op(108, 5, 540, "after_abort");

`ifdef MOD_MULT_RANGE_CHECK_EN
        // ---- range error: one-edge completion ----
        start_op(997, 1, "range");
        check_eq("range_ov0", int'(out_valid0), 1);
        check_eq("range_err0", int'(err0), 1);
        check_eq("range_res0", int'(result0), 0);
        check_eq("range_ov1", int'(out_valid1), 1);
        check_eq("range_err1", int'(err1), 1);
        $display("op range a=997 b=1 err0=%0d res0=%0d", err0, result0);
        take("range");
        full_op(108, 5, 540, "range_clear");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
